snn_wb_regs: RTL



---
 rtl/snn_wb_pkg.sv | 30 +++
 rtl/snn_spike_fifo.sv | 59 +++++
 rtl/snn_wb_regs.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/snn_wb_pkg.sv
// Shared register map, control/status bit positions and FIFO entry layout
// for the SNN Wishbone register block.
package snn_wb_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_IN     = 8'h08;
  localparam logic [7:0] REG_THRESH = 8'h0C;
  localparam logic [7:0] REG_DECAY  = 8'h10;
  localparam logic [7:0] REG_FIFO   = 8'h14;
  localparam logic [7:0] REG_TSTEP  = 8'h18;
  localparam logic [7:0] REG_STATE  = 8'h1C;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_SRST   = 1;
  localparam int CTRL_STEP   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVF      = 2;

  localparam int ENTRY_W = 18;

  typedef struct packed {
    logic [15:0] timestep;
    logic [1:0]  spike;
  } spike_entry_t;

endpackage

// File: rtl/snn_spike_fifo.sv
// Synchronous spike-result FIFO; a push into a full FIFO succeeds only when a
// pop happens in the same cycle, otherwise it is dropped and flagged.
module snn_spike_fifo
  import snn_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  spike_entry_t din,
  output spike_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  // DEPTH is a power of two (>= 2) so the pointers wrap naturally.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  spike_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty & ~clear;
  assign do_push  = push & ~clear & (~full | do_pop);
  assign overflow = push & ~clear & full & ~do_pop;
  assign dout     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snn_wb_regs.sv
// Wishbone register block driving the SNN core and collecting step results.
// Optional interrupt support is enabled with `define SNN_WB_IRQ_EN.
module snn_wb_regs
  import snn_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  THRESH_RST = 8'h80,
  parameter logic [7:0]  DECAY_RST  = 8'h01
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  snn_in,
  output logic [7:0]  snn_thresh,
  output logic [7:0]  snn_decay,
  output logic        snn_step,
  output logic        snn_rst,
  input  logic        snn_valid,
  input  logic [1:0]  snn_spike,
  input  logic [7:0]  snn_state,
  output logic        irq
);

  logic         ack_p1;
  logic [31:0]  dat_p1;
  logic         step_p1;
  logic         ctrl_en;
  logic         ctrl_srst;
  logic         ctrl_irq_en;
  logic [7:0]   in_q;
  logic [7:0]   thresh_q;
  logic [7:0]   decay_q;
  logic         ovf_q;
  logic [15:0]  tstep_q;

  logic         req_p0;
  logic         rd_p0;
  logic         wr_b0_p0;
  logic [7:0]   off_p0;
  logic [31:0]  rdata_p0;
  logic         step_p0;
  logic         ovf_clr_p0;

  spike_entry_t fifo_din;
  spike_entry_t fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_ovf;
  logic         fifo_pop;

  logic         unused_bits;

  // Stage p0: decode of the sampled request; ack masks back-to-back selection.
  assign req_p0     = wbs_stb_i & wbs_cyc_i & ~ack_p1 &
                      (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off_p0     = {wbs_adr_i[7:2], 2'b00};
  assign rd_p0      = req_p0 & ~wbs_we_i;
  assign wr_b0_p0   = req_p0 & wbs_we_i & wbs_sel_i[0];
  assign step_p0    = wr_b0_p0 & (off_p0 == REG_CTRL) &
                      wbs_dat_i[CTRL_STEP] & wbs_dat_i[CTRL_EN];
  assign ovf_clr_p0 = wr_b0_p0 & (off_p0 == REG_STATUS) & wbs_dat_i[STAT_OVF];
  assign fifo_pop   = rd_p0 & (off_p0 == REG_FIFO);
  assign fifo_din   = {tstep_q, snn_spike};

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:8], wbs_dat_i[3], wbs_sel_i[3:1]};

  always_comb begin
    rdata_p0 = '0;
    case (off_p0)
      REG_CTRL: begin
        rdata_p0[CTRL_EN]     = ctrl_en;
        rdata_p0[CTRL_SRST]   = ctrl_srst;
        rdata_p0[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      REG_STATUS: begin
        rdata_p0[STAT_NONEMPTY] = ~fifo_empty;
        rdata_p0[STAT_FULL]     = fifo_full;
        rdata_p0[STAT_OVF]      = ovf_q;
      end
      REG_IN:     rdata_p0 = {24'b0, in_q};
      REG_THRESH: rdata_p0 = {24'b0, thresh_q};
      REG_DECAY:  rdata_p0 = {24'b0, decay_q};
      REG_FIFO:   rdata_p0 = fifo_empty ? '0 : {{(32-ENTRY_W){1'b0}}, fifo_dout};
      REG_TSTEP:  rdata_p0 = {16'b0, tstep_q};
      REG_STATE:  rdata_p0 = {24'b0, snn_state};
      default:    rdata_p0 = '0;
    endcase
  end

  // Stage p1: registered response, register updates and result counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_p1    <= 1'b0;
      dat_p1    <= '0;
      step_p1   <= 1'b0;
      ctrl_en   <= 1'b0;
      ctrl_srst <= 1'b0;
      in_q      <= '0;
      thresh_q  <= THRESH_RST;
      decay_q   <= DECAY_RST;
      ovf_q     <= 1'b0;
      tstep_q   <= '0;
    end else begin
      ack_p1  <= req_p0;
      dat_p1  <= rd_p0 ? rdata_p0 : '0;
      step_p1 <= step_p0;
      if (wr_b0_p0) begin
        case (off_p0)
          REG_CTRL: begin
            ctrl_en   <= wbs_dat_i[CTRL_EN];
            ctrl_srst <= wbs_dat_i[CTRL_SRST];
          end
          REG_IN:     in_q     <= wbs_dat_i[7:0];
          REG_THRESH: thresh_q <= wbs_dat_i[7:0];
          REG_DECAY:  decay_q  <= wbs_dat_i[7:0];
          default: ;
        endcase
      end
      // A same-cycle overflow outranks the software clear.
      if (fifo_ovf) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_p0) begin
        ovf_q <= 1'b0;
      end
      if (ctrl_srst) begin
        tstep_q <= '0;
      end else if (snn_valid) begin
        tstep_q <= tstep_q + 16'd1;
      end
    end
  end

`ifdef SNN_WB_IRQ_EN
  logic irq_p1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_irq_en <= 1'b0;
      irq_p1      <= 1'b0;
    end else begin
      if (wr_b0_p0 && (off_p0 == REG_CTRL)) begin
        ctrl_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      end
      irq_p1 <= ctrl_irq_en & (~fifo_empty | ovf_q);
    end
  end

  assign irq = irq_p1;
`else
  assign ctrl_irq_en = 1'b0;
  assign irq         = 1'b0;
`endif

  snn_spike_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear    (ctrl_srst),
    .push     (snn_valid),
    .pop      (fifo_pop),
    .din      (fifo_din),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  assign wbs_ack_o  = ack_p1;
  assign wbs_dat_o  = dat_p1;
  assign snn_step   = step_p1;
  assign snn_rst    = wb_rst_i | ctrl_srst;
  assign snn_in     = in_q;
  assign snn_thresh = thresh_q;
  assign snn_decay  = decay_q;

endmodule
